// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: register numbers, exception codes,
// Status/Cause bit positions and reset values.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exccode_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_unit_v2_if.sv
// Pipeline <-> CP0 bus: MTC0/MFC0 ports, commit-point exception info and
// the redirect/status outputs back to the pipeline.
interface cp0_unit_v2_if #(
    parameter int HW_INT_NUM = 6
);
    logic                  we;
    logic [4:0]            waddr;
    logic [31:0]           wdata;
    logic                  re;
    logic [4:0]            raddr;
    logic [31:0]           rdata_o;
    logic [HW_INT_NUM-1:0] hw_int_i;
    logic                  exc_valid_i;
    logic [4:0]            exccode_i;
    logic                  eret_i;
    logic [31:0]           pc_i;
    logic                  in_delay_i;
    logic [31:0]           badvaddr_i;
    logic                  int_req_o;
    logic                  flush_o;
    logic                  flush_im_o;
    logic [31:0]           excaddr_o;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic                  timer_int_o;

    modport slave (
        input  we, waddr, wdata, re, raddr, hw_int_i, exc_valid_i, exccode_i,
               eret_i, pc_i, in_delay_i, badvaddr_i,
        output rdata_o, int_req_o, flush_o, flush_im_o, excaddr_o, status_o,
               cause_o, timer_int_o
    );

    modport master (
        output we, waddr, wdata, re, raddr, hw_int_i, exc_valid_i, exccode_i,
               eret_i, pc_i, in_delay_i, badvaddr_i,
        input  rdata_o, int_req_o, flush_o, flush_im_o, excaddr_o, status_o,
               cause_o, timer_int_o
    );

endinterface

// File: rtl/cp0_timer.sv
// CP0 timer: prescaled Count, Compare and the sticky timer interrupt.
module cp0_timer #(
    parameter int TIMER_DIV = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

    logic [PW-1:0] presc_q;

    // Advance the prescaler/Count, load on MTC0, and latch a Compare match until Compare is rewritten.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            presc_q     <= '0;
            count_o     <= '0;
            compare_o   <= '0;
            timer_int_o <= 1'b0;
        end else begin
            if (count_we) begin
                count_o <= wdata;
                presc_q <= '0;
            end else if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                count_o <= count_o + 32'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            if (compare_we) begin
                compare_o   <= wdata;
                timer_int_o <= 1'b0;
            end else if ((count_o == compare_o) && (compare_o != 32'd0)) begin
                timer_int_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit_v2.sv
// CP0 for the 5-stage MIPS core: Status/Cause/EPC/BadVAddr, exception entry
// and ERET, interrupt request generation, flush and redirect address.
module cp0_unit_v2
    import cp0_pkg::*;
#(
    parameter int          HW_INT_NUM   = 6,
    parameter int          TIMER_DIV    = 2,
    parameter int          SYNC_INT     = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
    parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03
) (
    input  logic         cpu_clk_50M,
    input  logic         cpu_rst,
    cp0_unit_v2_if.slave bus
);

    logic [31:0]           status_q;
    logic [31:0]           epc_q;
    logic [31:0]           badvaddr_q;
    logic                  cause_bd_q;
    logic [4:0]            cause_exc_q;
    logic [1:0]            cause_sw_ip_q;
    logic                  int_req_q;
    logic                  flush_im_q;
    logic [HW_INT_NUM-1:0] hw_int_s;
    logic [7:0]            cause_ip;
    logic [31:0]           cause_val;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  timer_int;
    logic                  mtc0_en;

    // MTC0 only takes effect when neither an exception nor ERET commits this cycle.
    assign mtc0_en = bus.we & ~bus.exc_valid_i & ~bus.eret_i;

    cp0_timer #(
        .TIMER_DIV (TIMER_DIV)
    ) u_timer (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .count_we    (mtc0_en && (bus.waddr == CP0_COUNT)),
        .compare_we  (mtc0_en && (bus.waddr == CP0_COMPARE)),
        .wdata       (bus.wdata),
        .count_o     (count),
        .compare_o   (compare),
        .timer_int_o (timer_int)
    );

    if (SYNC_INT != 0) begin : g_sync
        logic [HW_INT_NUM-1:0] sync1_q;
        logic [HW_INT_NUM-1:0] sync2_q;

        // Two-flop synchroniser for the asynchronous hardware interrupt lines.
        always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
            if (cpu_rst) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= bus.hw_int_i;
                sync2_q <= sync1_q;
            end
        end

        assign hw_int_s = sync2_q;
    end else begin : g_nosync
        assign hw_int_s = bus.hw_int_i;
    end

    // Assemble Cause.IP: software bits, hardware lines, and the timer on IP7.
    always_comb begin
        cause_ip                   = 8'h00;
        cause_ip[1:0]              = cause_sw_ip_q;
        cause_ip[2 +: HW_INT_NUM]  = hw_int_s;
        cause_ip[7]                = cause_ip[7] | timer_int;
    end

    assign cause_val = {cause_bd_q, timer_int, 14'd0, cause_ip, 1'b0, cause_exc_q, 2'b00};

    // Architectural register updates with priority exception > ERET > MTC0.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            status_q      <= STATUS_RESET;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            cause_bd_q    <= 1'b0;
            cause_exc_q   <= '0;
            cause_sw_ip_q <= '0;
        end else if (bus.exc_valid_i) begin
            if (!status_q[STATUS_EXL]) begin
                epc_q      <= bus.in_delay_i ? (bus.pc_i - 32'd4) : bus.pc_i;
                cause_bd_q <= bus.in_delay_i;
            end
            status_q[STATUS_EXL] <= 1'b1;
            cause_exc_q          <= bus.exccode_i;
            if (is_addr_exc(bus.exccode_i)) begin
                badvaddr_q <= bus.badvaddr_i;
            end
        end else if (bus.eret_i) begin
            status_q[STATUS_EXL] <= 1'b0;
        end else if (bus.we) begin
            case (bus.waddr)
                CP0_STATUS:   status_q      <= (status_q & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
                CP0_CAUSE:    cause_sw_ip_q <= bus.wdata[9:8];
                CP0_EPC:      epc_q         <= bus.wdata;
                CP0_BADVADDR: badvaddr_q    <= bus.wdata;
                default:      ;
            endcase
        end
    end

    // Registered interrupt request, suppressed right after exception entry and one-cycle flush echo.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            int_req_q  <= 1'b0;
            flush_im_q <= 1'b0;
        end else begin
            int_req_q  <= ~bus.exc_valid_i & status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                          & (|(cause_ip & status_q[STATUS_IM_LO +: 8]));
            flush_im_q <= bus.exc_valid_i | bus.eret_i;
        end
    end

    // MFC0 read mux; unimplemented registers and idle reads return zero.
    always_comb begin
        bus.rdata_o = 32'd0;
        if (bus.re) begin
            case (bus.raddr)
                CP0_BADVADDR: bus.rdata_o = badvaddr_q;
                CP0_COUNT:    bus.rdata_o = count;
                CP0_COMPARE:  bus.rdata_o = compare;
                CP0_STATUS:   bus.rdata_o = status_q;
                CP0_CAUSE:    bus.rdata_o = cause_val;
                CP0_EPC:      bus.rdata_o = epc_q;
                default:      bus.rdata_o = 32'd0;
            endcase
        end
    end

    // Redirect address; ERET forwards an EPC value being written in the same cycle.
    always_comb begin
        bus.excaddr_o = 32'd0;
        if (cpu_rst) begin
            bus.excaddr_o = RESET_PC;
        end else if (bus.exc_valid_i) begin
            bus.excaddr_o = EXC_VECTOR;
        end else if (bus.eret_i) begin
            bus.excaddr_o = (bus.we && (bus.waddr == CP0_EPC)) ? bus.wdata : epc_q;
        end
    end

    assign bus.flush_o     = bus.exc_valid_i | bus.eret_i;
    assign bus.flush_im_o  = flush_im_q;
    assign bus.int_req_o   = int_req_q;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_val;
    assign bus.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_unit_v2.sv
// Self-checking bench for cp0_unit_v2: directed scenarios plus randomized
// traffic, checked against a behavioural CP0 model through a scoreboard queue.
module tb_cp0_unit_v2;

    localparam int          TB_HW   = 6;
    localparam int          TB_DIV  = 2;
    localparam logic [31:0] TB_VEC  = 32'hBFC0_0380;
    localparam logic [31:0] TB_RPC  = 32'hBFC0_0000;
    localparam logic [31:0] TB_MASK = 32'h0000_FF03;

    logic cpu_clk_50M = 1'b0;
    logic cpu_rst     = 1'b1;

    cp0_unit_v2_if #(.HW_INT_NUM(TB_HW)) bus ();

    cp0_unit_v2 #(
        .HW_INT_NUM   (TB_HW),
        .TIMER_DIV    (TB_DIV),
        .SYNC_INT     (1),
        .EXC_VECTOR   (TB_VEC),
        .RESET_PC     (TB_RPC),
        .STATUS_WMASK (TB_MASK)
    ) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .bus         (bus)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] excaddr;
        logic [31:0] status;
        logic [31:0] cause;
        logic        flush;
        logic        flush_im;
        logic        int_req;
        logic        timer_int;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_status, m_epc, m_bva, m_compare, m_count_base;
    int unsigned m_cycles;
    logic        m_bd, m_ti, m_int_req, m_flush_im;
    logic [4:0]  m_code;
    logic [1:0]  m_sw_ip;
    logic [5:0]  m_hw_hist [2];
    logic [5:0]  hw_cur = 6'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_status     = 32'h1000_0000;
        m_epc        = 32'd0;
        m_bva        = 32'd0;
        m_compare    = 32'd0;
        m_count_base = 32'd0;
        m_cycles     = 0;
        m_bd         = 1'b0;
        m_ti         = 1'b0;
        m_int_req    = 1'b0;
        m_flush_im   = 1'b0;
        m_code       = 5'd0;
        m_sw_ip      = 2'd0;
        m_hw_hist[0] = 6'd0;
        m_hw_hist[1] = 6'd0;
    endtask

    task automatic driveIdle();
        bus.we          = 1'b0;
        bus.waddr       = 5'd0;
        bus.wdata       = 32'd0;
        bus.re          = 1'b0;
        bus.raddr       = 5'd0;
        bus.hw_int_i    = 6'd0;
        bus.exc_valid_i = 1'b0;
        bus.exccode_i   = 5'd0;
        bus.eret_i      = 1'b0;
        bus.pc_i        = 32'd0;
        bus.in_delay_i  = 1'b0;
        bus.badvaddr_i  = 32'd0;
    endtask

    // Drive one cycle of inputs, queue the expected outputs, advance the model past the next edge.
    task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic re, input logic [4:0] raddr, input logic [5:0] hw,
                                 input logic exc, input logic [4:0] code, input logic eret,
                                 input logic [31:0] pc, input logic in_delay, input logic [31:0] bad_addr);
        exp_t        e;
        logic [31:0] count_now;
        logic [7:0]  ip;
        logic [31:0] cause_now;
        logic        mtc0;
        logic        next_ti;

        bus.we = we; bus.waddr = waddr; bus.wdata = wdata;
        bus.re = re; bus.raddr = raddr; bus.hw_int_i = hw;
        bus.exc_valid_i = exc; bus.exccode_i = code; bus.eret_i = eret;
        bus.pc_i = pc; bus.in_delay_i = in_delay; bus.badvaddr_i = bad_addr;

        count_now = m_count_base + 32'(m_cycles / TB_DIV);
        ip = 8'(m_sw_ip) | (8'(m_hw_hist[1]) << 2);
        if (m_ti) ip[7] = 1'b1;
        cause_now = {m_bd, m_ti, 14'd0, ip, 1'b0, m_code, 2'b00};

        e.rdata = 32'd0;
        if (re) begin
            case (raddr)
                5'd8:    e.rdata = m_bva;
                5'd9:    e.rdata = count_now;
                5'd11:   e.rdata = m_compare;
                5'd12:   e.rdata = m_status;
                5'd13:   e.rdata = cause_now;
                5'd14:   e.rdata = m_epc;
                default: e.rdata = 32'd0;
            endcase
        end
        e.flush     = exc | eret;
        e.excaddr   = exc ? TB_VEC : (eret ? ((we && waddr == 5'd14) ? wdata : m_epc) : 32'd0);
        e.status    = m_status;
        e.cause     = cause_now;
        e.flush_im  = m_flush_im;
        e.int_req   = m_int_req;
        e.timer_int = m_ti;
        exp_q.push_back(e);

        mtc0       = we && !exc && !eret;
        next_ti    = (mtc0 && waddr == 5'd11) ? 1'b0
                   : (m_ti || (count_now == m_compare && m_compare != 32'd0));
        m_int_req  = !exc && m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 8'd0);
        m_flush_im = exc | eret;
        if (mtc0 && waddr == 5'd9) begin
            m_count_base = wdata;
            m_cycles     = 0;
        end else begin
            m_cycles++;
        end
        if (mtc0 && waddr == 5'd11) m_compare = wdata;
        m_ti = next_ti;

        if (exc) begin
            if (!m_status[1]) begin
                m_epc = in_delay ? pc - 32'd4 : pc;
                m_bd  = in_delay;
            end
            m_status[1] = 1'b1;
            m_code      = code;
            if (code == 5'd4 || code == 5'd5) m_bva = bad_addr;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end else if (mtc0) begin
            case (waddr)
                5'd12:   m_status = (m_status & ~TB_MASK) | (wdata & TB_MASK);
                5'd13:   m_sw_ip  = wdata[9:8];
                5'd14:   m_epc    = wdata;
                5'd8:    m_bva    = wdata;
                default: ;
            endcase
        end
        m_hw_hist[1] = m_hw_hist[0];
        m_hw_hist[0] = hw;
    endtask

    task automatic nextCycle();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic [4:0] raddr);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, raddr, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
            nextCycle();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_status"},   bus.status_o, 32'h1000_0000);
        checkOutput({tag, "_cause"},    bus.cause_o, 32'd0);
        checkOutput({tag, "_excaddr"},  bus.excaddr_o, 32'hBFC0_0000);
        checkOutput({tag, "_int_req"},  32'(bus.int_req_o), 32'd0);
        checkOutput({tag, "_flush_im"}, 32'(bus.flush_im_o), 32'd0);
        checkOutput({tag, "_timer"},    32'(bus.timer_int_o), 32'd0);
        checkOutput({tag, "_flush"},    32'(bus.flush_o), 32'd0);
        checkOutput({tag, "_rd_epc"},   bus.rdata_o, 32'd0);
    endtask

    // Scoreboard monitor: compare every queued cycle on the falling edge.
    always @(negedge cpu_clk_50M) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("rdata",     bus.rdata_o,            mon_e.rdata);
            checkOutput("excaddr",   bus.excaddr_o,          mon_e.excaddr);
            checkOutput("status",    bus.status_o,           mon_e.status);
            checkOutput("cause",     bus.cause_o,            mon_e.cause);
            checkOutput("flush",     32'(bus.flush_o),       32'(mon_e.flush));
            checkOutput("flush_im",  32'(bus.flush_im_o),    32'(mon_e.flush_im));
            checkOutput("int_req",   32'(bus.int_req_o),     32'(mon_e.int_req));
            checkOutput("timer_int", 32'(bus.timer_int_o),   32'(mon_e.timer_int));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        r_we, r_re, r_exc, r_eret, r_dly;
        logic [4:0]  r_wa, r_ra, r_code;
        logic [31:0] r_wd;

        driveIdle();
        bus.re    = 1'b1;
        bus.raddr = 5'd14;
        modelReset();
        @(posedge cpu_clk_50M);
        @(posedge cpu_clk_50M);
        #1;
        checkResetOutputs("reset");
        cpu_rst = 1'b0;

        // Timer: Count=0, Compare=5, interrupt after Count reaches 5
        applyStimulus(1'b1, 5'd9, 32'd0, 1'b1, 5'd9, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd11, 32'd5, 1'b1, 5'd11, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        idleCycles(9, 5'd9);
        checkOutput("timer_before_match", 32'(bus.timer_int_o), 32'd0);
        idleCycles(1, 5'd9);
        checkOutput("timer_after_match", 32'(bus.timer_int_o), 32'd1);

        // Compare write in the same cycle as a match keeps timer_int low
        applyStimulus(1'b1, 5'd11, 32'd100, 1'b1, 5'd13, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'd100, 1'b1, 5'd9, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd11, 32'd100, 1'b1, 5'd9, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("timer_clear_wins", 32'(bus.timer_int_o), 32'd0);
        applyStimulus(1'b1, 5'd11, 32'd0, 1'b1, 5'd11, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();

        // Hardware interrupt through the synchroniser, then interrupt exception entry
        applyStimulus(1'b1, 5'd12, 32'h0000_0401, 1'b1, 5'd12, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        hw_cur = 6'd1;
        idleCycles(2, 5'd13);
        checkOutput("int_req_latency_low", 32'(bus.int_req_o), 32'd0);
        idleCycles(1, 5'd13);
        checkOutput("int_req_raised", 32'(bus.int_req_o), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, hw_cur, 1'b1, 5'd0, 1'b0, 32'h8000_0100, 1'b0, 32'd0);
        nextCycle();
        checkOutput("int_exc_exl", 32'(bus.status_o[1]), 32'd1);
        checkOutput("int_exc_req_drop", 32'(bus.int_req_o), 32'd0);
        hw_cur = 6'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, hw_cur, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("eret_excaddr", bus.excaddr_o, 32'h8000_0100);
        nextCycle();

        // AdEL in a delay slot
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, hw_cur, 1'b1, 5'd4, 1'b0, 32'h8000_1004, 1'b1, 32'h3);
        #1;
        checkOutput("adel_flush", 32'(bus.flush_o), 32'd1);
        checkOutput("adel_excaddr", bus.excaddr_o, 32'hBFC0_0380);
        nextCycle();
        checkOutput("adel_flush_im", 32'(bus.flush_im_o), 32'd1);
        checkOutput("adel_bd", 32'(bus.cause_o[31]), 32'd1);
        checkOutput("adel_code", 32'(bus.cause_o[6:2]), 32'd4);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("adel_epc", bus.rdata_o, 32'h8000_1000);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("adel_badvaddr", bus.rdata_o, 32'h3);
        nextCycle();

        // Nested exception leaves EPC alone but updates ExcCode
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, hw_cur, 1'b1, 5'd12, 1'b0, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF);
        nextCycle();
        checkOutput("nested_code", 32'(bus.cause_o[6:2]), 32'd12);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("nested_epc", bus.rdata_o, 32'h8000_1000);
        nextCycle();

        // ERET with a same-cycle MTC0 to EPC forwards the new value but does not write it
        applyStimulus(1'b1, 5'd14, 32'h8000_2000, 1'b1, 5'd14, hw_cur, 1'b0, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("eret_fwd_excaddr", bus.excaddr_o, 32'h8000_2000);
        nextCycle();
        checkOutput("eret_fwd_exl", 32'(bus.status_o[1]), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, hw_cur, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("eret_fwd_epc_kept", bus.rdata_o, 32'h8000_1000);
        nextCycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0:       r_wa = 5'd8;
                1:       r_wa = 5'd9;
                2:       r_wa = 5'd11;
                3:       r_wa = 5'd12;
                4:       r_wa = 5'd13;
                5:       r_wa = 5'd14;
                default: r_wa = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 6))
                0:       r_ra = 5'd8;
                1:       r_ra = 5'd9;
                2:       r_ra = 5'd11;
                3:       r_ra = 5'd12;
                4:       r_ra = 5'd13;
                5:       r_ra = 5'd14;
                default: r_ra = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 6))
                0:       r_code = 5'd0;
                1:       r_code = 5'd4;
                2:       r_code = 5'd5;
                3:       r_code = 5'd8;
                4:       r_code = 5'd9;
                5:       r_code = 5'd10;
                default: r_code = 5'd12;
            endcase
            r_wd   = ((r_wa == 5'd9 || r_wa == 5'd11) && $urandom_range(0, 1) == 1)
                   ? 32'($urandom_range(0, 40)) : 32'($urandom);
            r_we   = ($urandom_range(0, 99) < 35);
            r_re   = ($urandom_range(0, 99) < 85);
            r_exc  = ($urandom_range(0, 99) < 8);
            r_eret = !r_exc && ($urandom_range(0, 99) < 8);
            r_dly  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) hw_cur = 6'($urandom);
            applyStimulus(r_we, r_wa, r_wd, r_re, r_ra, hw_cur, r_exc, r_code, r_eret,
                          {32'($urandom) & 32'hFFFF_FFFC}, r_dly, 32'($urandom));
            nextCycle();
        end

        // Reset asserted mid-exception returns everything to reset values immediately
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, hw_cur, 1'b1, 5'd4, 1'b0, 32'h8000_3000, 1'b0, 32'h55);
        nextCycle();
        driveIdle();
        bus.re    = 1'b1;
        bus.raddr = 5'd14;
        #1;
        cpu_rst = 1'b1;
        #1;
        checkResetOutputs("midrun");
        nextCycle();
        cpu_rst = 1'b0;
        modelReset();
        hw_cur = 6'd0;
        idleCycles(6, 5'd9);

        @(negedge cpu_clk_50M);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
